control_pipeline: RTL
=====================

CONTROL_PIPELINE -- requirements
Module: control_pipeline

Interface
REQ-001 Parameter REG_AW, default 5: register-specifier width.
REQ-002 Parameter CNT_W, default 16: stall-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 inOpcode  input  6  ID-stage opcode.
REQ-006 inRs  input  REG_AW  ID-stage rs.
REQ-007 inRt  input  REG_AW  ID-stage rt.
REQ-008 inValid  input  1  ID holds a real instruction.
REQ-009 inFlush  input  1  kill ID instruction (taken branch/jump).
REQ-010 outStall  output  1  freeze PC and IF/ID this cycle.
REQ-011 outIllegal  output  1  ID opcode undefined and inValid=1 (combinational).
REQ-012 outCtrlEX  output  15  control word in EX stage.
REQ-013 outCtrlMEM  output  15  control word in MEM stage.
REQ-014 outCtrlWB  output  15  control word in WB stage.
REQ-015 outValidEX/outValidMEM/outValidWB  output  1 each  stage valid.
REQ-016 outStallCnt  output  CNT_W  saturating count of stall cycles.

Function
REQ-017 Word layout SHALL be JMP[14:13], EX[12:7], MEM_RD[6], MEM_WR[5], SIZE[4:2], WB[1:0]; bit1=RegWrite, bit0=MemToReg/link.
REQ-018 Decode SHALL be combinational: 0x00 R-type 00_001100_00_000_10; 0x23 lw 00_000001_10_000_11; 0x20 lb ..._10_101_11; 0x24 lbu ..._10_001_11; 0x21 lh ..._10_110_11; 0x25 lhu ..._10_010_11; 0x28/0x29/0x2B sb/sh/sw 00_000001_01_{001,010,000}_00; 0x04 beq 00_010000_00_000_00; 0x05 bne 00_110000_00_000_00; 0x08/0x0C/0x0D/0x0E immediate 00_000111_00_000_10; 0x02 j 10_000000_00_000_01; 0x03 jal 11_000000_00_000_11; all don't-care bits resolve to 0.
REQ-019 Undefined opcodes (including 0x14) SHALL decode to all-zero word.
REQ-020 Load-use hazard SHALL be: outValidEX=1, outCtrlEX[6]=1, EX rt!=0, inValid=1, and EX rt equals inRs or inRt.
REQ-021 EX rt SHALL be inRt registered alongside the EX control word.
REQ-022 On hazard with inFlush=0: outStall=1; EX loads zero word, valid 0; MEM/WB advance normally.
REQ-023 On inFlush=1: EX loads zero word, valid 0; outStall=0 (flush wins over hazard).
REQ-024 Otherwise EX SHALL load decoded word and inValid one cycle after ID presentation.
REQ-025 MEM SHALL load EX word with bits[14:7] cleared; WB SHALL load MEM word with bits[6:2] cleared; valid follows each.
REQ-026 Total latency ID->WB SHALL be exactly 3 cycles; no back-pressure beyond outStall.
REQ-027 outStallCnt SHALL increment per outStall cycle, holding at all-ones.

Reset
REQ-028 While rst=0 at a clock edge: all stage words 0, all valids 0, outStallCnt 0, stored EX rt 0; outStall=0 during reset.
REQ-029 Reset mid-stream SHALL discard all in-flight words; first post-reset ID instruction reaches EX one cycle after rst=1.

Configuration
REQ-030 Macro CTRL_PIPE_HAZARD_EN: defined -> REQ-020..022 and REQ-027 active.
REQ-031 Undefined -> outStall tied 0, outStallCnt tied 0, no hazard bubbles; flush unchanged.

Structure
REQ-032 Shared package SHALL hold field bit-position constants, opcode constants and the 15-bit decoded-word constants.
REQ-033 Combinational decoder SHALL be a sub-module ctrl_decode (inOpcode -> word, illegal flag); pipeline, hazard and counter logic in control_pipeline.

Verification
REQ-034 Opcode 0x00 valid, no hazard -> outCtrlEX=00_001100_00_000_10 next cycle; outCtrlMEM=0x0002 cycle after; outCtrlWB=0x0002 cycle after.
REQ-035 lw rt=5 then add rs=5 -> outStall=1 for 1 cycle, outCtrlEX=0 and outValidEX=0 next cycle, outStallCnt=1; add enters EX following cycle.
REQ-036 lw rt=0 then instruction rs=0 -> outStall stays 0.
REQ-037 Hazard and inFlush same cycle -> outStall=0, EX bubble, outStallCnt unchanged.
REQ-038 Opcode 0x3F valid -> outIllegal=1, outCtrlEX=0 next cycle with outValidEX=1.
REQ-039 rst=0 with all stages valid -> all outputs 0 after one edge; macro undefined build: REQ-035 stimulus gives outStall=0.

Source files
------------

// File: rtl/control_pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module  : control_pipeline_pkg
// Brief   : Control-word field positions, opcodes, decoded words and stage masks
// Revision: 1.0
// ============================================================================
package control_pipeline_pkg;

  localparam int CTRL_W = 15;

  typedef logic [CTRL_W-1:0] ctrl_word_t;

  localparam int JMP_HI     = 14;
  localparam int JMP_LO     = 13;
  localparam int EX_HI      = 12;
  localparam int EX_LO      = 7;
  localparam int MEM_RD_BIT = 6;
  localparam int MEM_WR_BIT = 5;
  localparam int SIZE_HI    = 4;
  localparam int SIZE_LO    = 2;
  localparam int WB_HI      = 1;
  localparam int WB_LO      = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam ctrl_word_t W_NONE  = 15'h0000;
  localparam ctrl_word_t W_RTYPE = 15'h0602;
  localparam ctrl_word_t W_LW    = 15'h00C3;
  localparam ctrl_word_t W_LB    = 15'h00D7;
  localparam ctrl_word_t W_LBU   = 15'h00C7;
  localparam ctrl_word_t W_LH    = 15'h00DB;
  localparam ctrl_word_t W_LHU   = 15'h00CB;
  localparam ctrl_word_t W_SB    = 15'h00A4;
  localparam ctrl_word_t W_SH    = 15'h00A8;
  localparam ctrl_word_t W_SW    = 15'h00A0;
  localparam ctrl_word_t W_BEQ   = 15'h0800;
  localparam ctrl_word_t W_BNE   = 15'h1800;
  localparam ctrl_word_t W_IMM   = 15'h0382;
  localparam ctrl_word_t W_J     = 15'h4001;
  localparam ctrl_word_t W_JAL   = 15'h6003;

  // MEM drops JMP/EX fields; WB additionally drops MEM_RD/MEM_WR/SIZE.
  localparam ctrl_word_t MEM_KEEP = 15'h007F;
  localparam ctrl_word_t WB_KEEP  = 15'h0003;

  function automatic ctrl_word_t mem_stage_word(input ctrl_word_t w);
    return w & MEM_KEEP;
  endfunction

  function automatic ctrl_word_t wb_stage_word(input ctrl_word_t w);
    return w & WB_KEEP;
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_pipeline_decode.sv
`default_nettype none
// ============================================================================
// Module  : ctrl_decode
// Brief   : Combinational opcode -> 15-bit control word, flags undefined opcodes
// Revision: 1.0
// ============================================================================
module ctrl_decode
  import control_pipeline_pkg::*;
(
  input  logic [5:0]  in_opcode,
  output logic [14:0] out_word,
  output logic        out_illegal
);

  always_comb begin
    out_word    = W_NONE;
    out_illegal = 1'b0;
    case (in_opcode)
      OP_RTYPE: out_word = W_RTYPE;
      OP_LW:    out_word = W_LW;
      OP_LB:    out_word = W_LB;
      OP_LBU:   out_word = W_LBU;
      OP_LH:    out_word = W_LH;
      OP_LHU:   out_word = W_LHU;
      OP_SB:    out_word = W_SB;
      OP_SH:    out_word = W_SH;
      OP_SW:    out_word = W_SW;
      OP_BEQ:   out_word = W_BEQ;
      OP_BNE:   out_word = W_BNE;
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: out_word = W_IMM;
      OP_J:     out_word = W_J;
      OP_JAL:   out_word = W_JAL;
      default:  out_illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_pipeline.sv
`default_nettype none
// ============================================================================
// Module  : control_pipeline
// Brief   : EX/MEM/WB control-word pipeline with load-use stall and flush.
//           Macro CTRL_PIPE_HAZARD_EN enables hazard stalls and stall counter.
// Revision: 1.0
// ============================================================================
module control_pipeline
  import control_pipeline_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        inOpcode,
  input  logic [REG_AW-1:0] inRs,
  input  logic [REG_AW-1:0] inRt,
  input  logic              inValid,
  input  logic              inFlush,
  output logic              outStall,
  output logic              outIllegal,
  output logic [14:0]       outCtrlEX,
  output logic [14:0]       outCtrlMEM,
  output logic [14:0]       outCtrlWB,
  output logic              outValidEX,
  output logic              outValidMEM,
  output logic              outValidWB,
  output logic [CNT_W-1:0]  outStallCnt
);

  ctrl_word_t        dec_word;
  logic              dec_illegal;
  logic              hazard;
  logic              bubble;

  ctrl_word_t        ex_word_q,  ex_word_d;
  ctrl_word_t        mem_word_q, mem_word_d;
  ctrl_word_t        wb_word_q,  wb_word_d;
  logic              ex_valid_q,  ex_valid_d;
  logic              mem_valid_q, mem_valid_d;
  logic              wb_valid_q,  wb_valid_d;
  logic [REG_AW-1:0] ex_rt_q,     ex_rt_d;

  ctrl_decode u_decode (
    .in_opcode   (inOpcode),
    .out_word    (dec_word),
    .out_illegal (dec_illegal)
  );

  assign outIllegal = dec_illegal & inValid;

  always_comb begin
    hazard = 1'b0;
`ifdef CTRL_PIPE_HAZARD_EN
    hazard = ex_valid_q & ex_word_q[MEM_RD_BIT] & (ex_rt_q != '0) & inValid &
             ((ex_rt_q == inRs) | (ex_rt_q == inRt));
`endif
    // Flush and hazard both inject a bubble; flush additionally suppresses the stall.
    bubble      = inFlush | hazard;
    ex_word_d   = bubble ? W_NONE : dec_word;
    ex_valid_d  = ~bubble & inValid;
    ex_rt_d     = inRt;
    mem_word_d  = mem_stage_word(ex_word_q);
    mem_valid_d = ex_valid_q;
    wb_word_d   = wb_stage_word(mem_word_q);
    wb_valid_d  = mem_valid_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_word_q   <= W_NONE;
      mem_word_q  <= W_NONE;
      wb_word_q   <= W_NONE;
      ex_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      ex_rt_q     <= '0;
    end else begin
      ex_word_q   <= ex_word_d;
      mem_word_q  <= mem_word_d;
      wb_word_q   <= wb_word_d;
      ex_valid_q  <= ex_valid_d;
      mem_valid_q <= mem_valid_d;
      wb_valid_q  <= wb_valid_d;
      ex_rt_q     <= ex_rt_d;
    end
  end

  assign outCtrlEX   = ex_word_q;
  assign outCtrlMEM  = mem_word_q;
  assign outCtrlWB   = wb_word_q;
  assign outValidEX  = ex_valid_q;
  assign outValidMEM = mem_valid_q;
  assign outValidWB  = wb_valid_q;

`ifdef CTRL_PIPE_HAZARD_EN
  logic             stall;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall       = hazard & ~inFlush & rst;
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign outStall    = stall;
  assign outStallCnt = stall_cnt_q;
`else
  logic unused_hazard_inputs;
  assign unused_hazard_inputs = ^{inRs, ex_rt_q, hazard};
  assign outStall    = 1'b0;
  assign outStallCnt = '0;
`endif

endmodule
`default_nettype wire
